// File: rtl/alu32_arbiter.sv
// alu32_arbiter
//   Shares one external combinational ALU32 between two requesters. Requests
//   are arbitrated round-robin. The granted operands and function code are
//   registered onto the ALU inputs, and the ALU result and flags are captured
//   one cycle later. The response is then presented, tagged with the ID of
//   the requester that issued it. Only one operation is in flight at a time.
//
//   Optional feature: define ALU32_ARB_DIVZ_EN to detect divide-by-zero
//   (func 4'b0011 with b == 0) at the handshake. When it is detected, the
//   response is forced to data = all ones, flags = 0 and err = 1.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   reqN_valid/ready            request handshake for requester N (0/1)
//   reqN_a, reqN_b, reqN_func   request payload for requester N
//   alu_a, alu_b, alu_func      registered operands/function to the ALU
//   alu_out, alu_carry, alu_zr,
//   alu_sign, alu_parity        ALU result and flags
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_data,
//   rsp_flags, rsp_err          response payload; flags = {carry, zr, sign, parity}
module alu32_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_func,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_func,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_func,
  input  logic [W-1:0] alu_out,
  input  logic         alu_carry,
  input  logic         alu_zr,
  input  logic         alu_sign,
  input  logic         alu_parity,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         id_q, id_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_func_q, alu_func_d;
  logic [W-1:0] rsp_data_q, rsp_data_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;

  logic         gnt0, gnt1;
  logic         hs0, hs1;
  logic [W-1:0] sel_a, sel_b;
  logic [3:0]   sel_func;

`ifdef ALU32_ARB_DIVZ_EN
  logic divz_q, divz_d;
  logic rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    // Round-robin: a lone requester always wins. On contention the winner is
    // the requester that was not served last.
    gnt0       = req0_valid & (~req1_valid | last_q);
    gnt1       = req1_valid & (~req0_valid | ~last_q);
    req0_ready = (state_q == IDLE) & gnt0;
    req1_ready = (state_q == IDLE) & gnt1;
    hs0        = req0_valid & req0_ready;
    hs1        = req1_valid & req1_ready;

    sel_a    = hs1 ? req1_a    : req0_a;
    sel_b    = hs1 ? req1_b    : req0_b;
    sel_func = hs1 ? req1_func : req0_func;

    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_func_d  = alu_func_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
`ifdef ALU32_ARB_DIVZ_EN
    divz_d      = divz_q;
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (hs0 | hs1) begin
          state_d    = EXEC;
          id_d       = hs1;
          last_d     = hs1;
          alu_a_d    = sel_a;
          alu_b_d    = sel_b;
          alu_func_d = sel_func;
`ifdef ALU32_ARB_DIVZ_EN
          divz_d     = (sel_func == 4'b0011) && (sel_b == '0);
`endif
        end
      end
      EXEC: begin
        state_d = RESP;
`ifdef ALU32_ARB_DIVZ_EN
        // A divide-by-zero decided at the handshake overrides the ALU output.
        rsp_data_d  = divz_q ? '1 : alu_out;
        rsp_flags_d = divz_q ? 4'b0000
                             : {alu_carry, alu_zr, alu_sign, alu_parity};
        rsp_err_d   = divz_q;
`else
        rsp_data_d  = alu_out;
        rsp_flags_d = {alu_carry, alu_zr, alu_sign, alu_parity};
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
`ifdef ALU32_ARB_DIVZ_EN
      divz_q      <= 1'b0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_func_q  <= alu_func_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
`ifdef ALU32_ARB_DIVZ_EN
      divz_q      <= divz_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
`ifdef ALU32_ARB_DIVZ_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
